// File: rtl/memory_writeback_stage_if.sv
// Bundle of EX/MEM latch inputs, dcache request/response and MEM/WB outputs
// shared between the memory_writeback_stage and its environment.
interface memory_writeback_stage_if;
  logic        valid_MEM;
  logic        RegWr_MEM;
  logic        memtoReg_MEM;
  logic        memWr_MEM;
  logic        halt_MEM;
  logic [4:0]  wsel_MEM;
  logic [31:0] alu_MEM;
  logic [31:0] store_MEM;
  logic        flush;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        mem_stall;
  logic        RegWr_WB;
  logic [4:0]  wsel_WB;
  logic [31:0] wdat_WB;
  logic        halt_WB;
  logic        mem_err;

  modport master (
    output valid_MEM, RegWr_MEM, memtoReg_MEM, memWr_MEM, halt_MEM,
           wsel_MEM, alu_MEM, store_MEM, flush, dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
           RegWr_WB, wsel_WB, wdat_WB, halt_WB, mem_err
  );

  modport slave (
    input  valid_MEM, RegWr_MEM, memtoReg_MEM, memWr_MEM, halt_MEM,
           wsel_MEM, alu_MEM, store_MEM, flush, dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
           RegWr_WB, wsel_WB, wdat_WB, halt_WB, mem_err
  );
endinterface

// File: rtl/memory_writeback_stage.sv
// MIPS memory stage with dcache handshake, stall generation, watchdog and
// the MEM/WB pipeline register.
module memory_writeback_stage #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic CLK,
  input  logic nRST,
  memory_writeback_stage_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] counter;
  logic             live;
  logic             req;

  // Flush can only kill an instruction before its request has been issued.
  assign live = bus.valid_MEM & ~(bus.flush & (state == IDLE));
  assign req  = live & ~bus.halt_MEM & (bus.memtoReg_MEM | bus.memWr_MEM)
              & (state != HALTED);

  assign bus.dmemREN   = req & bus.memtoReg_MEM;
  assign bus.dmemWEN   = req & bus.memWr_MEM & ~bus.memtoReg_MEM;
  assign bus.dmemaddr  = bus.alu_MEM;
  assign bus.dmemstore = bus.store_MEM;
  assign bus.mem_stall = req & ~bus.dhit;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state       <= IDLE;
      counter     <= '0;
      bus.mem_err <= 1'b0;
      bus.halt_WB <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (live & bus.halt_MEM) begin
            state       <= HALTED;
            bus.halt_WB <= 1'b1;
          end else if (req & ~bus.dhit) begin
            state   <= BUSY;
            counter <= CNT_W'(1);
          end
        end
        BUSY: begin
          if (bus.dhit) begin
            state   <= IDLE;
            counter <= '0;
          end else begin
            // Watchdog saturates at TIMEOUT and keeps the pipeline frozen.
            if (counter != CNT_W'(TIMEOUT))
              counter <= counter + CNT_W'(1);
            if (counter == CNT_W'(TIMEOUT))
              bus.mem_err <= 1'b1;
          end
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      bus.RegWr_WB <= 1'b0;
      bus.wsel_WB  <= '0;
      bus.wdat_WB  <= '0;
    end else if (bus.mem_stall | (state == HALTED)) begin
      bus.RegWr_WB <= 1'b0;
    end else begin
      bus.RegWr_WB <= live & bus.RegWr_MEM & ~bus.halt_MEM;
      bus.wsel_WB  <= bus.wsel_MEM;
      bus.wdat_WB  <= bus.memtoReg_MEM ? bus.dmemload : bus.alu_MEM;
    end
  end

endmodule
